// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pkg : shared types and helpers for the VGA framebuffer            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fb_pkg;

  typedef enum logic [0:0] {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_t;

  // Pixels are packed {r,g,b}, each channel one third of the pixel width.
  localparam int c_CHANNELS = 3;
  localparam int c_R_IDX    = 2;
  localparam int c_G_IDX    = 1;
  localparam int c_B_IDX    = 0;

  function automatic int unsigned fb_ch_w(input int unsigned color_w);
    return color_w / c_CHANNELS;
  endfunction

  function automatic int unsigned fb_ch_lsb(input int unsigned color_w,
                                            input int unsigned idx);
    return idx * (color_w / c_CHANNELS);
  endfunction

  function automatic int unsigned fb_addr(input int unsigned x,
                                          input int unsigned y,
                                          input int unsigned fb_w);
    return y * fb_w + x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_dpram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_dpram : simple dual-port RAM, one write port, registered read,     |
// | read-first on same-address collision.                                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fb_dpram #(
  parameter  int WIDTH  = 12,
  parameter  int DEPTH  = 76800,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/vga_framebuffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_framebuffer : upscaling pixel framebuffer with write port,        |
// | hardware clear and 2-cycle sync-aligned scan-out.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_framebuffer
  import fb_pkg::*;
#(
  parameter int                 X_WIDTH     = 10,
  parameter int                 Y_WIDTH     = 10,
  parameter int                 FB_W        = 320,
  parameter int                 FB_H        = 240,
  parameter int                 SCALE_LOG2  = 1,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_display_on,
  input  logic [X_WIDTH-1:0] i_hpos,
  input  logic [Y_WIDTH-1:0] i_vpos,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [X_WIDTH-1:0] wr_x,
  input  logic [Y_WIDTH-1:0] wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_frame_start
);

  localparam int DEPTH  = FB_W * FB_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int AW1    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // ---------------- scan pipeline ----------------
  logic [X_WIDTH-1:0] w_fx;
  logic [Y_WIDTH-1:0] w_fy;
  logic [AW1-1:0]     w_rd_addr_ext;
  logic               w_rd_in_fb;
  logic               w_first_px;

  assign w_fx          = i_hpos >> SCALE_LOG2;
  assign w_fy          = i_vpos >> SCALE_LOG2;
  assign w_rd_addr_ext = AW1'(fb_addr(32'(w_fx), 32'(w_fy), 32'(FB_W)));
  assign w_rd_in_fb    = i_display_on
                      && (32'(w_fx) < 32'(FB_W))
                      && (32'(w_fy) < 32'(FB_H))
                      && (w_rd_addr_ext < AW1'(DEPTH));
  assign w_first_px    = i_display_on && (i_hpos == '0) && (i_vpos == '0);

  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_in_fb0, r_in_fb1;
  logic               r_hs0, r_vs0, r_fs0;
  logic [COLOR_W-1:0] w_ram_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addr     <= '0;
      r_in_fb0      <= 1'b0;
      r_hs0         <= 1'b0;
      r_vs0         <= 1'b0;
      r_fs0         <= 1'b0;
      r_in_fb1      <= 1'b0;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      r_rd_addr     <= w_rd_addr_ext[ADDR_W-1:0];
      r_in_fb0      <= w_rd_in_fb;
      r_hs0         <= i_hsync;
      r_vs0         <= i_vsync;
      r_fs0         <= w_first_px;
      r_in_fb1      <= r_in_fb0;
      o_hsync       <= r_hs0;
      o_vsync       <= r_vs0;
      o_frame_start <= r_fs0;
    end
  end

  // Out-of-frame or blanked pixels are forced black after the RAM stage.
  assign o_color = r_in_fb1 ? w_ram_q : '0;

  // ---------------- write / clear FSM ----------------
  fb_state_t         r_state;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic [AW1-1:0]     w_wr_addr_ext;
  logic               w_wr_in_range;
  logic               w_we;
  logic [ADDR_W-1:0]  w_waddr;
  logic [COLOR_W-1:0] w_wdata;

  assign w_wr_addr_ext = AW1'(fb_addr(32'(wr_x), 32'(wr_y), 32'(FB_W)));
  assign w_wr_in_range = (32'(wr_x) < 32'(FB_W))
                      && (32'(wr_y) < 32'(FB_H))
                      && (w_wr_addr_ext < AW1'(DEPTH));

  // Reset suppresses the RAM write so an aborted clear stops cleanly.
  assign w_we    = !reset && ((r_state == FB_CLEAR)
                           || (wr_valid && wr_ready && w_wr_in_range));
  assign w_waddr = (r_state == FB_CLEAR) ? r_clr_cnt : w_wr_addr_ext[ADDR_W-1:0];
  assign w_wdata = (r_state == FB_CLEAR) ? CLEAR_COLOR : wr_color;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FB_IDLE;
      r_clr_cnt  <= '0;
      clear_busy <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      case (r_state)
        FB_IDLE: begin
          if (clear_req) begin
            r_state    <= FB_CLEAR;
            r_clr_cnt  <= '0;
            clear_busy <= 1'b1;
            wr_ready   <= 1'b0;
          end
        end
        FB_CLEAR: begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_state    <= FB_IDLE;
            r_clr_cnt  <= '0;
            clear_busy <= 1'b0;
            wr_ready   <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= FB_IDLE;
          clear_busy <= 1'b0;
          wr_ready   <= 1'b1;
        end
      endcase
    end
  end

  fb_dpram #(
    .WIDTH (COLOR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_vga_framebuffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_framebuffer : directed self-checking bench, 8x4 framebuffer    |
// | at scale 1 (dut0) and scale 2 (dut1).                                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vga_framebuffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hs, vs;
  logic        on0, wv0, rdy0, clr0, busy0, ohs0, ovs0, fs0;
  logic [9:0]  hp0, vp0, wx0, wy0;
  logic [11:0] wc0, col0;
  logic        on1, wv1, rdy1, clr1, busy1, ohs1, ovs1, fs1;
  logic [9:0]  hp1, vp1, wx1, wy1;
  logic [11:0] wc1, col1;

  vga_framebuffer #(
    .X_WIDTH(10), .Y_WIDTH(10), .FB_W(8), .FB_H(4), .SCALE_LOG2(0),
    .COLOR_W(12), .CLEAR_COLOR(12'h5A5)
  ) dut0 (
    .clk(clk), .reset(rst), .i_hsync(hs), .i_vsync(vs), .i_display_on(on0),
    .i_hpos(hp0), .i_vpos(vp0), .wr_valid(wv0), .wr_ready(rdy0),
    .wr_x(wx0), .wr_y(wy0), .wr_color(wc0), .clear_req(clr0),
    .clear_busy(busy0), .o_hsync(ohs0), .o_vsync(ovs0), .o_color(col0),
    .o_frame_start(fs0)
  );

  vga_framebuffer #(
    .X_WIDTH(10), .Y_WIDTH(10), .FB_W(8), .FB_H(4), .SCALE_LOG2(1),
    .COLOR_W(12), .CLEAR_COLOR(12'h000)
  ) dut1 (
    .clk(clk), .reset(rst), .i_hsync(hs), .i_vsync(vs), .i_display_on(on1),
    .i_hpos(hp1), .i_vpos(vp1), .wr_valid(wv1), .wr_ready(rdy1),
    .wr_x(wx1), .wr_y(wy1), .wr_color(wc1), .clear_req(clr1),
    .clear_busy(busy1), .o_hsync(ohs1), .o_vsync(ovs1), .o_color(col1),
    .o_frame_start(fs1)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] model [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input int x, input int y, input logic [11:0] c);
    wx0 = 10'(x); wy0 = 10'(y); wc0 = c; wv0 = 1'b1;
    tick;
    wv0 = 1'b0;
    if (x < 8 && y < 4) model[y*8+x] = c;
  endtask

  task automatic rd0(input int x, input int y, output logic [11:0] c);
    hp0 = 10'(x); vp0 = 10'(y); on0 = 1'b1;
    tick; tick;
    c = col0;
    on0 = 1'b0;
  endtask

  task automatic rd1(input int x, input int y, output logic [11:0] c);
    hp1 = 10'(x); vp1 = 10'(y); on1 = 1'b1;
    tick; tick;
    c = col1;
    on1 = 1'b0;
  endtask

  task automatic readback0(input string tag);
    logic [11:0] c;
    for (int i = 0; i < 32; i++) begin
      rd0(i % 8, i / 8, c);
      chk(tag, c, model[i]);
    end
  endtask

  // Counts busy cycles, checks wr_ready stays low, optionally re-pulses clear_req.
  task automatic run_clear0(input int pulse_at, output int cycles);
    cycles = 0;
    while (busy0 === 1'b1 && cycles < 100) begin
      chk("clr_ready_low", rdy0, 0);
      clr0 = (cycles == pulse_at);
      cycles++;
      tick;
    end
    clr0 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] c;
    int n, prev_p, p, n_pulse;

    rst = 1'b1; hs = 1'b0; vs = 1'b0;
    on0 = 0; wv0 = 0; clr0 = 0; hp0 = 0; vp0 = 0; wx0 = 0; wy0 = 0; wc0 = 0;
    on1 = 0; wv1 = 0; clr1 = 0; hp1 = 0; vp1 = 0; wx1 = 0; wy1 = 0; wc1 = 0;
    tick; tick; tick;
    chk("rst_color", col0, 0);
    chk("rst_hsync", ohs0, 0);
    chk("rst_vsync", ovs0, 0);
    chk("rst_fstart", fs0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", rdy0, 1);
    rst = 1'b0;
    tick;

    // Initialise RAM via a clear; a clear_req mid-way must not restart it.
    clr0 = 1'b1; tick; clr0 = 1'b0;
    run_clear0(5, n);
    chk("clr_init_len", n, 32);
    for (int i = 0; i < 32; i++) model[i] = 12'h5A5;

    for (int i = 0; i < 32; i++) wr0(i % 8, i / 8, 12'h100 + 12'(i));
    wr0(3, 2, 12'hF00);
    rd0(3, 2, c); chk("px_3_2", c, 12'hF00);
    rd0(2, 2, c); chk("px_2_2", c, 12'h112);
    rd0(4, 2, c); chk("px_4_2", c, 12'h114);
    rd0(3, 1, c); chk("px_3_1", c, 12'h10B);

    rd0(9, 1, c); chk("oob_x", c, 0);
    hp0 = 3; vp0 = 2; on0 = 1'b0;
    tick; tick;
    chk("blank", col0, 0);

    hs = 1'b1; tick; chk("hs_d1", ohs0, 0); tick; chk("hs_d2", ohs0, 1);
    hs = 1'b0; tick; chk("hs_f1", ohs0, 1); tick; chk("hs_f2", ohs0, 0);
    vs = 1'b1; tick; chk("vs_d1", ovs0, 0); tick; chk("vs_d2", ovs0, 1);
    vs = 1'b0; tick; tick; chk("vs_f2", ovs0, 0);

    wr0(8, 0, 12'hEEE);
    chk("oor_ready", rdy0, 1);
    readback0("oor_rb");

    // Write in the same cycle as clear_req, then the clear overwrites it.
    wx0 = 0; wy0 = 0; wc0 = 12'hABC; wv0 = 1'b1; clr0 = 1'b1;
    chk("req_ready", rdy0, 1);
    tick;
    wv0 = 1'b0; clr0 = 1'b0;
    chk("clr_busy_on", busy0, 1);
    run_clear0(-1, n);
    chk("clr_len", n, 32);
    chk("clr_ready_back", rdy0, 1);
    for (int i = 0; i < 32; i++) model[i] = 12'h5A5;
    readback0("clr_rb");

    for (int i = 0; i < 32; i++) wr0(i % 8, i / 8, 12'h200 + 12'(i));
    clr0 = 1'b1; tick; clr0 = 1'b0;
    repeat (10) tick;
    chk("abort_busy_pre", busy0, 1);
    rst = 1'b1;
    tick;
    chk("abort_busy", busy0, 0);
    chk("abort_ready", rdy0, 1);
    chk("abort_color", col0, 0);
    chk("abort_hsync", ohs0, 0);
    chk("abort_fstart", fs0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) model[i] = 12'h5A5;
    readback0("abort_rb");

    // Scale-2 instance.
    clr1 = 1'b1; tick; clr1 = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 100) begin n++; tick; end
    chk("s_clr_len", n, 32);
    wx1 = 1; wy1 = 0; wc1 = 12'h0F0; wv1 = 1'b1; tick;
    wx1 = 0; wy1 = 0; wc1 = 12'h00F; tick;
    wv1 = 1'b0;
    rd1(2, 0, c); chk("s_2_0", c, 12'h0F0);
    rd1(3, 0, c); chk("s_3_0", c, 12'h0F0);
    rd1(2, 1, c); chk("s_2_1", c, 12'h0F0);
    rd1(3, 1, c); chk("s_3_1", c, 12'h0F0);
    rd1(1, 1, c); chk("s_1_1", c, 12'h00F);
    rd1(4, 0, c); chk("s_4_0", c, 12'h000);

    // Two raster frames of 16x8 screen pixels, one pixel per cycle.
    n_pulse = 0;
    prev_p  = -1;
    for (int it = 0; it <= 256; it++) begin
      p = it % 128;
      if (it < 256) begin
        hp1 = 10'(p % 16); vp1 = 10'(p / 16); on1 = 1'b1;
      end else begin
        on1 = 1'b0;
      end
      tick;
      if (fs1 === 1'b1) begin
        n_pulse++;
        chk("fs_pixel", prev_p, 0);
        chk("fs_color", col1, 12'h00F);
      end
      prev_p = p;
    end
    chk("fs_count", n_pulse, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_framebuffer.md
Name: vga_framebuffer

Overview:
- Parametrised pixel framebuffer between the `vga` timing generator and the external VGA pins.
- Holds a FB_W x FB_H image of COLOR_W-bit pixels in dual-port block RAM.
- Accepts pixel writes over a valid/ready port and supports a hardware clear-screen sequence.
- Scans pixels out in step with hpos/vpos, with integer upscaling by 2^SCALE_LOG2, and re-aligns hsync/vsync to the RAM read latency.

Parameters:
- X_WIDTH, 10, width of i_hpos.
- Y_WIDTH, 10, width of i_vpos.
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in pixels.
- SCALE_LOG2, 1, screen pixels per framebuffer pixel = 2^SCALE_LOG2 in each axis.
- COLOR_W, 12, pixel width; packing is {r,g,b}, COLOR_W/3 bits each.
- CLEAR_COLOR, 12'h000, value written by the clear sequence.
- Derived, not overridable: DEPTH = FB_W*FB_H, ADDR_W = $clog2(DEPTH).

Ports:
- clk  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_hsync  in  1  hsync from vga.
- i_vsync  in  1  vsync from vga.
- i_display_on  in  1  active-video flag from vga.
- i_hpos  in  X_WIDTH  current column.
- i_vpos  in  Y_WIDTH  current row.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  write port can accept a request.
- wr_x  in  X_WIDTH  framebuffer column.
- wr_y  in  Y_WIDTH  framebuffer row.
- wr_color  in  COLOR_W  pixel value to write.
- clear_req  in  1  one-cycle request to fill the framebuffer with CLEAR_COLOR.
- clear_busy  out  1  clear sequence in progress.
- o_hsync  out  1  hsync delayed 2 cycles.
- o_vsync  out  1  vsync delayed 2 cycles.
- o_color  out  COLOR_W  pixel to the DAC.
- o_frame_start  out  1  one-cycle pulse, aligned with o_color, on the first active pixel (hpos=0, vpos=0).

Behaviour:
- Reset: o_color=0, o_hsync=0, o_vsync=0, o_frame_start=0, clear_busy=0, wr_ready=1, FSM=IDLE, clear counter=0. RAM contents are not altered by reset.
- Read pipeline, fixed 2-cycle latency:
  - Stage 0 (registered): fx = hpos>>SCALE_LOG2, fy = vpos>>SCALE_LOG2; rd_addr = fy*FB_W + fx; in_fb = display_on & (fx<FB_W) & (fy<FB_H); hsync, vsync and frame_start are delayed alongside.
  - Stage 1: RAM registered read. o_color = in_fb_d ? ram_q : 0. Syncs appear at the output 2 cycles after the inputs.
- Address arithmetic: FB_W is a constant multiplier; intermediate width is ADDR_W+1. No wrap-around: any out-of-range coordinate gives black on output.
- Write FSM, states IDLE and CLEAR:
  - IDLE: wr_ready=1. A write is accepted when wr_valid & wr_ready. If wr_x<FB_W and wr_y<FB_H, RAM[wr_y*FB_W+wr_x] = wr_color, visible to reads from the next cycle. Out-of-range writes are accepted and dropped.
  - IDLE + clear_req: go to CLEAR and reset the counter to 0. If wr_valid is also high that cycle, the write is still accepted first; the clear then overwrites it.
  - CLEAR: wr_ready=0, clear_busy=1. Each cycle RAM[cnt]=CLEAR_COLOR and cnt++. When cnt==DEPTH-1 is written, go to IDLE next cycle; clear takes exactly DEPTH cycles. clear_req during CLEAR is ignored.
  - reset during CLEAR: go to IDLE immediately; the partial clear is left as-is.
- Read/write collision on the same address in the same cycle: the read returns the old data (read-first).
- Scan-out continues during CLEAR; transient mixed frames are acceptable.

Decomposition:
- Package fb_pkg: enum fb_state_t {FB_IDLE, FB_CLEAR}; a function fb_addr(x,y) parametrised by FB_W; the COLOR_W channel-slicing localparams.
- Sub-module fb_dpram (WIDTH, DEPTH): simple dual-port RAM with one write port and one registered read port, read-first, written so it infers BRAM.
- vga_framebuffer contains the scan pipeline, sync alignment and write/clear FSM.

Test Plan (bench uses FB_W=8, FB_H=4, SCALE_LOG2=0, COLOR_W=12 unless noted):
- Write (x=3,y=2,12'hF00) then scan hpos=3,vpos=2, display_on=1 -> o_color=12'hF00 exactly 2 cycles later; neighbouring pixels = previous value.
- Scan hpos=9, vpos=1 (fx>=FB_W), and display_on=0 at a written pixel -> o_color=0. Toggle i_hsync -> o_hsync follows 2 cycles later.
- Pulse clear_req with wr_valid=1 (x=0,y=0,12'hABC) in the same cycle -> write accepted; clear_busy high for exactly 32 cycles; wr_ready=0 throughout; afterwards every pixel reads CLEAR_COLOR, including (0,0).
- Write with wr_x=8, wr_y=0 -> wr_ready stays 1; RAM unchanged; a full readback matches the pre-write contents.
- Assert reset at clear cycle 10 -> next cycle clear_busy=0, wr_ready=1, all outputs 0; addresses 0..9 hold CLEAR_COLOR, the rest hold their old data.
- SCALE_LOG2=1: write (1,0,12'h0F0) -> screen pixels hpos 2,3 at vpos 0,1 all output 12'h0F0; o_frame_start pulses once per frame, aligned with pixel (0,0).
